// File: rtl/serial_pkg.sv
// Shared definitions for the serial datapath blocks (word collector, two's-complement FSM bench).
package serial_pkg;

  typedef enum logic {
    ST_COLLECT = 1'b0,
    ST_FULL    = 1'b1
  } collect_state_t;

  localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/serial_word_collector_if.sv
// Serial-in / parallel-out handshake bundle for serial_word_collector.
interface serial_word_collector_if
  import serial_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);

  logic             in;
  logic             in_valid;
  logic             sof;
  logic             in_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready;

  modport master (
    output in, in_valid, sof, out_ready,
    input  in_ready, out_data, out_valid
  );

  modport slave (
    input  in, in_valid, sof, out_ready,
    output in_ready, out_data, out_valid
  );

endinterface

// File: rtl/serial_bit_counter.sv
// Modulo-WIDTH bit counter with sync clear, load-to-1 and a wrap flag on the last count.
module serial_bit_counter #(
  parameter  int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             load1,
  output logic [CNT_W-1:0] count,
  output logic             wrap
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  // load1 wins over inc, so an abort never reports a wrap
  assign wrap = inc & ~load1 & (count == LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load1) begin
      count <= CNT_W'(1);
    end else if (inc) begin
      count <= wrap ? '0 : count + 1'b1;
    end
  end

endmodule

// File: rtl/serial_word_collector.sv
// LSB-first bit-serial to WIDTH-bit parallel converter with a one-word skid.
// Optional COLLECTOR_ERR_EN adds err_abort pulse and saturating abort_cnt outputs.
module serial_word_collector
  import serial_pkg::*;
#(
  parameter  int WIDTH = DEFAULT_WIDTH,
  localparam int CNT_W = $clog2(WIDTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  serial_word_collector_if.slave bus
`ifdef COLLECTOR_ERR_EN
  ,
  output logic                  err_abort,
  output logic [7:0]            abort_cnt
`endif
);

  collect_state_t   state;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] word;
  logic [CNT_W-1:0] count;
  logic             accept;
  logic             abort;
  logic             wrap;

  assign accept = bus.in_valid & bus.in_ready;
  assign abort  = accept & bus.sof & (count != '0);
  assign word   = {bus.in, shreg[WIDTH-1:1]};

  serial_bit_counter #(
    .WIDTH (WIDTH)
  ) u_bit_counter (
    .clk   (clk),
    .rst   (rst),
    .inc   (accept),
    .load1 (abort),
    .count (count),
    .wrap  (wrap)
  );

  // shreg doubles as the skid slot: in FULL it holds the parked word and no bits are accepted
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ST_COLLECT;
      shreg         <= '0;
      bus.in_ready  <= 1'b1;
      bus.out_data  <= '0;
      bus.out_valid <= 1'b0;
    end else begin
      if (bus.out_valid && bus.out_ready) begin
        bus.out_valid <= 1'b0;
      end
      case (state)
        ST_COLLECT: begin
          if (accept) begin
            shreg <= word;
            if (wrap) begin
              if (!bus.out_valid || bus.out_ready) begin
                bus.out_data  <= word;
                bus.out_valid <= 1'b1;
              end else begin
                state        <= ST_FULL;
                bus.in_ready <= 1'b0;
              end
            end
          end
        end
        ST_FULL: begin
          if (bus.out_ready) begin
            bus.out_data  <= shreg;
            bus.out_valid <= 1'b1;
            state         <= ST_COLLECT;
            bus.in_ready  <= 1'b1;
          end
        end
        default: begin
          state        <= ST_COLLECT;
          bus.in_ready <= 1'b1;
        end
      endcase
    end
  end

`ifdef COLLECTOR_ERR_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      err_abort <= 1'b0;
      abort_cnt <= '0;
    end else begin
      err_abort <= abort;
      if (abort && abort_cnt != 8'hFF) begin
        abort_cnt <= abort_cnt + 8'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_serial_word_collector.sv
// Scoreboard bench for serial_word_collector: a bit-list reference model predicts words,
// a monitor pops and compares on every output transfer. Checks COLLECTOR_ERR_EN outputs when defined.
module tb_serial_word_collector;
  import serial_pkg::*;

  localparam int WIDTH = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  serial_word_collector_if #(.WIDTH(WIDTH)) bus ();

`ifdef COLLECTOR_ERR_EN
  logic       err_abort;
  logic [7:0] abort_cnt;
`endif

  serial_word_collector #(
    .WIDTH (WIDTH)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef COLLECTOR_ERR_EN
    ,
    .err_abort (err_abort),
    .abort_cnt (abort_cnt)
`endif
  );

  int checks   = 0;
  int failures = 0;

  logic [WIDTH-1:0] exp_q[$];
  logic             bits_q[$];
  logic             err_pend = 1'b0;
  logic             exp_err  = 1'b0;
  int               cnt_pend = 0;
  int               exp_cnt  = 0;

  bit   rand_ready = 1'b0;
  bit   rand_gaps  = 1'b0;
  logic fixed_ready = 1'b1;
  logic rand_bit    = 1'b1;

  always @(posedge clk) begin
    #1;
    rand_bit = 1'($urandom_range(0, 1));
  end
  assign bus.out_ready = rand_ready ? rand_bit : fixed_ready;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
    end
  endtask

  // Reference model: a word is simply the last WIDTH accepted bits since the last start, LSB first
  always @(negedge clk) begin
    logic [WIDTH-1:0] w;
    exp_err = err_pend;
    exp_cnt = cnt_pend;
    if (rst) begin
      bits_q.delete();
      exp_q.delete();
      err_pend = 1'b0;
      cnt_pend = 0;
    end else if (bus.in_valid && bus.in_ready) begin
      err_pend = 1'b0;
      if (bus.sof && bits_q.size() != 0) begin
        bits_q.delete();
        err_pend = 1'b1;
        if (cnt_pend < 255) cnt_pend++;
      end
      bits_q.push_back(bus.in);
      if (bits_q.size() == WIDTH) begin
        w = '0;
        for (int i = 0; i < WIDTH; i++) w[i] = bits_q[i];
        exp_q.push_back(w);
        bits_q.delete();
      end
    end else begin
      err_pend = 1'b0;
    end
  end

  // Monitor: compares on every transfer and checks data holds while stalled
  logic             stall = 1'b0;
  logic [WIDTH-1:0] held  = '0;
  always @(negedge clk) begin
    logic [WIDTH-1:0] e;
    #1;
    if (rst) begin
      stall = 1'b0;
    end else begin
`ifdef COLLECTOR_ERR_EN
      check_output("err_abort", 32'(err_abort), 32'(exp_err));
      check_output("abort_cnt", 32'(abort_cnt), 32'(exp_cnt));
`endif
      if (stall) check_output("hold_data", 32'(bus.out_data), 32'(held));
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("[TB] FAIL unexpected_word: got 0x%0h expected no word", bus.out_data);
        end else begin
          e = exp_q.pop_front();
          check_output("word", 32'(bus.out_data), 32'(e));
        end
      end
      stall = bus.out_valid && !bus.out_ready;
      held  = bus.out_data;
    end
  end

  // Inputs change 1 time unit after the rising edge; returns 1 unit after the accepting edge
  task automatic drive_bit(input logic b, input logic s);
    int guard;
    guard = 0;
    bus.in       = b;
    bus.sof      = s;
    bus.in_valid = 1'b1;
    @(negedge clk);
    while (!bus.in_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 200) begin
      checks++;
      failures++;
      $display("[TB] FAIL in_ready_timeout: got 0 expected 1 within 200 cycles");
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.sof      = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic apply_stimulus(input logic [WIDTH-1:0] w, input logic s);
    for (int i = 0; i < WIDTH; i++) begin
      if (rand_gaps && $urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
      drive_bit(w[i], s && (i == 0));
    end
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [WIDTH-1:0] tc;
    int               k;
    bus.in       = 1'b0;
    bus.in_valid = 1'b0;
    bus.sof      = 1'b0;
    rst          = 1'b1;
    idle(2);
    check_output("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check_output("rst_out_data", 32'(bus.out_data), 32'd0);
    check_output("rst_in_ready", 32'(bus.in_ready), 32'd1);
    rst = 1'b0;
    idle(1);

    // Single word with consumer ready: valid right after the last accept, for one cycle
    fixed_ready = 1'b1;
    apply_stimulus(8'hA5, 1'b1);
    check_output("lat_valid", 32'(bus.out_valid), 32'd1);
    check_output("lat_data", 32'(bus.out_data), 32'hA5);
    idle(1);
    check_output("one_cycle_valid", 32'(bus.out_valid), 32'd0);

    // Back-to-back words into a stalled consumer fill the skid
    fixed_ready = 1'b0;
    apply_stimulus(8'hA5, 1'b1);
    apply_stimulus(8'h3C, 1'b1);
    check_output("full_in_ready", 32'(bus.in_ready), 32'd0);
    check_output("full_out_data", 32'(bus.out_data), 32'hA5);
    check_output("full_out_valid", 32'(bus.out_valid), 32'd1);
    idle(2);
    check_output("stall_out_data", 32'(bus.out_data), 32'hA5);
    fixed_ready = 1'b1;
    idle(4);
    check_output("skid_drained", 32'(exp_q.size()), 32'd0);
    check_output("skid_in_ready", 32'(bus.in_ready), 32'd1);

    // Partial word aborted by sof
    drive_bit(1'b1, 1'b0);
    drive_bit(1'b1, 1'b0);
    drive_bit(1'b1, 1'b0);
    apply_stimulus(8'h0F, 1'b1);
    check_output("abort_data", 32'(bus.out_data), 32'h0F);
    idle(2);
`ifdef COLLECTOR_ERR_EN
    check_output("abort_cnt_one", 32'(abort_cnt), 32'd1);
`endif

    // Gaps between every bit
    for (int i = 0; i < WIDTH; i++) begin
      tc = 8'h81;
      drive_bit(tc[i], i == 0);
      idle(1);
    end
    check_output("gap_valid", 32'(bus.out_valid), 32'd0);
    tc = 8'h81;
    check_output("gap_word_seen", 32'(exp_q.size()), 32'd0);

    // Reset mid-word discards the partial bits
    for (int i = 0; i < 5; i++) drive_bit(1'b1, i == 0);
    rst = 1'b1;
    idle(1);
    check_output("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    check_output("midrst_out_data", 32'(bus.out_data), 32'd0);
    check_output("midrst_in_ready", 32'(bus.in_ready), 32'd1);
    rst = 1'b0;
    idle(1);
    apply_stimulus(8'h55, 1'b0);
    check_output("after_rst_data", 32'(bus.out_data), 32'h55);
    idle(1);

    // Two's complement of 6 arriving LSB first
    tc = 8'h00 - 8'h06;
    apply_stimulus(tc, 1'b1);
    check_output("twos_comp_data", 32'(bus.out_data), 32'hFA);
    idle(2);

    // Randomised traffic with back-pressure, gaps and aborts
    rand_ready = 1'b1;
    rand_gaps  = 1'b1;
    for (int n = 0; n < 150; n++) begin
      if ($urandom_range(0, 4) == 0) begin
        k = $urandom_range(1, WIDTH - 1);
        for (int j = 0; j < k; j++) drive_bit(1'($urandom_range(0, 1)), 1'b0);
        apply_stimulus(WIDTH'($urandom), 1'b1);
      end else begin
        apply_stimulus(WIDTH'($urandom), 1'($urandom_range(0, 1)));
      end
    end

    rand_ready  = 1'b0;
    rand_gaps   = 1'b0;
    fixed_ready = 1'b1;
    k = 0;
    while ((exp_q.size() != 0 || bus.out_valid) && k < 50) begin
      idle(1);
      k++;
    end
    idle(2);
    check_output("final_drained", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
